concat_rdma: RTL

//  Read DMA for the Concat engine. Fetches one feature tensor from DDR over the MCIF read path: w_in+1 pixels x ch_div_Tout

---
 rtl/concat_rdma_pkg.sv | 29 ++
 rtl/concat_rdma_fifo.sv | 48 ++++
 rtl/concat_rdma.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/concat_rdma_pkg.sv
// Shared Concat DMA constants: burst geometry, beat width, rd_req_pd field layout and FSM state type.
package concat_rdma_pkg;
  localparam int AXI_BURST_LEN      = 16;
  localparam int LOG2_AXI_BURST_LEN = 4;
  localparam int TOUT               = 4;
  localparam int LOG2_TOUT          = 2;
  localparam int MAX_DAT_DW         = 8;
  localparam int PIXEL_DATA_BYTES   = TOUT * MAX_DAT_DW / 8;
  localparam int LOG2_W             = 12;
  localparam int LOG2_CH            = 10;
  localparam int CH_W               = LOG2_CH - LOG2_TOUT;
  localparam int BURST_BYTES        = AXI_BURST_LEN * PIXEL_DATA_BYTES;

  // rd_req_pd = {base[31:0], length, offset[31:0]}; layout shared with the MCIF read arbiter
  localparam int RD_REQ_OFF_LSB  = 0;
  localparam int RD_REQ_LEN_LSB  = 32;
  localparam int RD_REQ_BASE_LSB = 32 + LOG2_AXI_BURST_LEN;
  localparam int RD_REQ_PD_W     = 64 + LOG2_AXI_BURST_LEN;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  function automatic logic [RD_REQ_PD_W-1:0] mk_rd_req_pd(
    input logic [31:0]                   base,
    input logic [LOG2_AXI_BURST_LEN-1:0] len,
    input logic [31:0]                   off
  );
    return {base, len, off};
  endfunction
endpackage

// File: rtl/concat_rdma_fifo.sv
// Synchronous first-word-fall-through FIFO; push while full is accepted only alongside a pop.
module concat_rdma_fifo #(
  parameter int DW    = 33,
  parameter int DEPTH = 64
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DW-1:0]            din,
  input  logic                     rd_en,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push, pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign pop   = rd_en && !empty;
  assign push  = wr_en && (!full || pop);
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/concat_rdma.sv
// Concat read DMA: credit-gated burst command generator, FWFT response buffer, in-order beat stream.
// Optional CONCAT_RDMA_PERF_EN adds a saturating stall counter output.
module concat_rdma
  import concat_rdma_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int DW         = TOUT * MAX_DAT_DW
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LOG2_W-1:0]      w_in,
  input  logic [CH_W-1:0]        ch_div_Tout,
  input  logic [31:0]            feature_base_addr,
  input  logic [25:0]            feature_surface_stride,
  output logic                   rdma_done,
  output logic                   Concat2mcif_rd_req_vld,
  input  logic                   Concat2mcif_rd_req_rdy,
  output logic [RD_REQ_PD_W-1:0] Concat2mcif_rd_req_pd,
  input  logic                   mcif2Concat_rd_rsp_vld,
  input  logic [DW-1:0]          mcif2Concat_rd_rsp_pd,
  output logic                   mcif2Concat_rd_rsp_rdy,
  output logic                   dat_out_vld,
  output logic [DW-1:0]          dat_out_pd,
  output logic                   dat_out_last,
  input  logic                   dat_out_rdy
`ifdef CONCAT_RDMA_PERF_EN
  ,
  output logic [31:0]            perf_stall_cnt
`endif
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BL2 = LOG2_AXI_BURST_LEN;
  localparam logic [AW+1:0] DEPTH_LIM = (AW+2)'(FIFO_DEPTH);

  state_t              state;
  logic [LOG2_W-1:0]   w_cfg, burst_cnt, rsp_pix;
  logic [CH_W-1:0]     ch_cfg, surf_cnt, out_surf;
  logic [31:0]         base_cfg, burst_off, surf_off;
  logic [25:0]         stride_cfg;
  logic [AW:0]         outstanding, fifo_count;
  logic [AW+1:0]       reserved, need;
  logic [BL2-1:0]      cur_len;
  logic                last_burst, last_surf, credit_ok, start_acc;
  logic                req_hs, rsp_hs, out_hs;
  logic                fifo_full, fifo_empty;
  logic [DW:0]         fifo_dout;

  assign start_acc  = start && (state == S_IDLE);
  assign req_hs     = Concat2mcif_rd_req_vld && Concat2mcif_rd_req_rdy;
  assign rsp_hs     = mcif2Concat_rd_rsp_vld && mcif2Concat_rd_rsp_rdy;
  assign out_hs     = dat_out_vld && dat_out_rdy;
  assign last_burst = (burst_cnt == (w_cfg >> BL2));
  assign last_surf  = (surf_cnt == ch_cfg - CH_W'(1));
  assign cur_len    = last_burst ? w_cfg[BL2-1:0] : BL2'(AXI_BURST_LEN - 1);
  // Reserved space covers beats already buffered plus beats promised by issued commands.
  assign reserved   = (AW+2)'(outstanding) + (AW+2)'(fifo_count);
  assign need       = reserved + (AW+2)'(cur_len) + (AW+2)'(1);
  assign credit_ok  = (need <= DEPTH_LIM);

  // Stray beats in IDLE are not ours to take; this also holds rsp_rdy low through reset.
  assign mcif2Concat_rd_rsp_rdy = !fifo_full && (state != S_IDLE);
  assign dat_out_vld  = !fifo_empty;
  assign dat_out_pd   = dat_out_vld ? fifo_dout[DW-1:0] : '0;
  assign dat_out_last = dat_out_vld && fifo_dout[DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= S_IDLE;
      w_cfg                  <= '0;
      ch_cfg                 <= '0;
      base_cfg               <= '0;
      stride_cfg             <= '0;
      burst_cnt              <= '0;
      surf_cnt               <= '0;
      burst_off              <= '0;
      surf_off               <= '0;
      Concat2mcif_rd_req_vld <= 1'b0;
      Concat2mcif_rd_req_pd  <= '0;
      rdma_done              <= 1'b0;
    end else begin
      rdma_done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          w_cfg      <= w_in;
          ch_cfg     <= ch_div_Tout;
          base_cfg   <= feature_base_addr;
          stride_cfg <= feature_surface_stride;
          burst_cnt  <= '0;
          surf_cnt   <= '0;
          burst_off  <= '0;
          surf_off   <= '0;
          state      <= S_RUN;
        end
        S_RUN: begin
          if (Concat2mcif_rd_req_vld) begin
            if (Concat2mcif_rd_req_rdy) begin
              Concat2mcif_rd_req_vld <= 1'b0;
              if (last_burst) begin
                burst_cnt <= '0;
                burst_off <= '0;
                surf_cnt  <= surf_cnt + CH_W'(1);
                surf_off  <= surf_off + 32'(stride_cfg);
                if (last_surf) state <= S_DRAIN;
              end else begin
                burst_cnt <= burst_cnt + LOG2_W'(1);
                burst_off <= burst_off + 32'(BURST_BYTES);
              end
            end
          end else if (credit_ok) begin
            Concat2mcif_rd_req_vld <= 1'b1;
            Concat2mcif_rd_req_pd  <= mk_rd_req_pd(base_cfg, cur_len, burst_off + surf_off);
          end
        end
        S_DRAIN: if (out_hs && dat_out_last && out_surf == ch_cfg - CH_W'(1)) begin
          state     <= S_IDLE;
          rdma_done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Commands add their whole burst; each accepted beat moves one unit from outstanding to the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) outstanding <= '0;
    else outstanding <= outstanding
                        + (req_hs ? (AW+1)'(cur_len) + (AW+1)'(1) : '0)
                        - (rsp_hs ? (AW+1)'(1) : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pix  <= '0;
      out_surf <= '0;
    end else if (start_acc) begin
      rsp_pix  <= '0;
      out_surf <= '0;
    end else begin
      if (rsp_hs) rsp_pix <= (rsp_pix == w_cfg) ? '0 : rsp_pix + LOG2_W'(1);
      if (out_hs && dat_out_last) out_surf <= out_surf + CH_W'(1);
    end
  end

  concat_rdma_fifo #(.DW(DW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (rsp_hs),
    .din   ({rsp_pix == w_cfg, mcif2Concat_rd_rsp_pd}),
    .rd_en (dat_out_rdy),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef CONCAT_RDMA_PERF_EN
  // With vld = !empty the two stall kinds are exclusive, so one increment per cycle suffices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_stall_cnt <= '0;
    else if (start_acc) perf_stall_cnt <= '0;
    else if ((state != S_IDLE) && (fifo_empty || !dat_out_rdy) && (perf_stall_cnt != 32'hFFFF_FFFF))
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif
endmodule
